// File: rtl/enc4to2_hs.sv
// Sequential 4-to-2 encoder with enable and a valid/ready output handshake.
// Define ENC4TO2_ROUND_ROBIN_EN for round-robin selection (default: fixed priority, y0 highest).
module enc4to2_hs (
  input  logic       clk,
  input  logic       rst,
  input  logic       e,
  input  logic       y0,
  input  logic       y1,
  input  logic       y2,
  input  logic       y3,
  input  logic       ready,
  output logic [1:0] a,
  output logic       valid,
  output logic       multi
);

  typedef enum logic {IDLE, HOLD} state_t;

  state_t     state_q, state_d;
  logic [1:0] a_q, a_d;
  logic       multi_q, multi_d;
  logic [3:0] y;
  logic       any_req;
  logic       multi_hot;
  logic       capture;
  logic [1:0] sel;

  assign y         = {y3, y2, y1, y0};
  assign any_req   = |y;
  assign multi_hot = (y & (y - 4'd1)) != 4'd0;
  // A new code may load from IDLE, or from HOLD in the same edge the old one is accepted.
  assign capture   = e && any_req && ((state_q == IDLE) || ready);

`ifdef ENC4TO2_ROUND_ROBIN_EN
  logic [1:0] last_q, last_d;
  logic [1:0] idx;
  logic       found;

  always_comb begin
    sel   = last_q;
    idx   = 2'd0;
    found = 1'b0;
    for (int k = 0; k < 4; k++) begin
      idx = last_q + 2'(k + 1);
      if (!found && y[idx]) begin
        sel   = idx;
        found = 1'b1;
      end
    end
  end

  assign last_d = capture ? sel : last_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) last_q <= 2'd3;
    else     last_q <= last_d;
  end
`else
  always_comb begin
    sel = 2'd0;
    if      (y[0]) sel = 2'd0;
    else if (y[1]) sel = 2'd1;
    else if (y[2]) sel = 2'd2;
    else if (y[3]) sel = 2'd3;
  end
`endif

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    multi_d = multi_q;
    if (capture) begin
      state_d = HOLD;
      a_d     = sel;
      multi_d = multi_hot;
    end else if ((state_q == HOLD) && ready) begin
      state_d = IDLE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= 2'b00;
      multi_q <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      multi_q <= multi_d;
    end
  end

  assign a     = a_q;
  assign valid = (state_q == HOLD);
  assign multi = multi_q;

endmodule
